mem_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one external memory port among `NUM_CONSUMERS` fetchers/LSUs. It uses the same level-valid/level-ready consumer handshake as the memory controllers, so it can stand in front of a single-channel memory. Fair rotation replaces lowest-index-first selection, which bounds every requester's wait to `NUM_CONSUMERS-1` transactions. It also exports the current grant and a saturating grant counter for performance debug.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_rr_arbiter_picker.sv | 37 +++
 rtl/mem_rr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the round-robin memory arbiter: FSM state encoding and a
// constant-evaluable log2 helper used to size grant indices.
package mem_arb_pkg;

  localparam int STATE_BITS = 3;

  localparam logic [STATE_BITS-1:0] S_IDLE        = 3'd0;
  localparam logic [STATE_BITS-1:0] S_READ_WAIT   = 3'd1;
  localparam logic [STATE_BITS-1:0] S_WRITE_WAIT  = 3'd2;
  localparam logic [STATE_BITS-1:0] S_READ_RELAY  = 3'd3;
  localparam logic [STATE_BITS-1:0] S_WRITE_RELAY = 3'd4;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE        = S_IDLE,
    ST_READ_WAIT   = S_READ_WAIT,
    ST_WRITE_WAIT  = S_WRITE_WAIT,
    ST_READ_RELAY  = S_READ_RELAY,
    ST_WRITE_RELAY = S_WRITE_RELAY
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_picker.sv
// Combinational round-robin picker: rotates the request vector so rr_ptr sits
// at bit 0, priority-encodes the lowest set bit, then rotates the index back.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDB = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDB-1:0] ptr,
  output logic           found,
  output logic [IDB-1:0] winner
);

  localparam logic [IDB:0] N_W = (IDB+1)'(N);

  logic [N-1:0]   rot;
  logic [IDB-1:0] offset;
  logic [IDB:0]   sum;

  always_comb begin
    rot    = N'({req, req} >> ptr);
    found  = 1'b0;
    offset = '0;
    // Descending scan so the lowest set bit (closest to ptr) is kept last.
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) begin
        found  = 1'b1;
        offset = IDB'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= N_W) sum = sum - N_W;
    winner = sum[IDB-1:0];
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_CONSUMERS requesters.
// Handshake: valid is a level held by the requester until it sees ready; ready is a level held until the requester drops valid.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int WRITE_ENABLE  = 1,
  parameter int CNT_BITS      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
  input  logic [ADDR_BITS-1:0]              consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
  output logic [DATA_BITS-1:0]              consumer_read_data [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
  input  logic [ADDR_BITS-1:0]              consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]              consumer_write_data [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
  output logic                              mem_read_valid,
  output logic [ADDR_BITS-1:0]              mem_read_address,
  input  logic                              mem_read_ready,
  input  logic [DATA_BITS-1:0]              mem_read_data,
  output logic                              mem_write_valid,
  output logic [ADDR_BITS-1:0]              mem_write_address,
  output logic [DATA_BITS-1:0]              mem_write_data,
  input  logic                              mem_write_ready,
  output logic                              arb_busy,
  output logic [clog2(NUM_CONSUMERS)-1:0]   arb_grant_id,
  output logic [CNT_BITS-1:0]               arb_grant_count,
  output logic [STATE_BITS-1:0]             arb_state
);

  localparam int ID_BITS = clog2(NUM_CONSUMERS);

  arb_state_e                 state_q, state_d;
  logic [ID_BITS-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]         grant_id_q, grant_id_d;
  logic [CNT_BITS-1:0]        grant_count_q, grant_count_d;
  logic                       mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]       mem_read_addr_q, mem_read_addr_d;
  logic                       mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]       mem_write_addr_q, mem_write_addr_d;
  logic [DATA_BITS-1:0]       mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]   cons_read_ready_q, cons_read_ready_d;
  logic [NUM_CONSUMERS-1:0]   cons_write_ready_q, cons_write_ready_d;
  logic [DATA_BITS-1:0]       cons_read_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]       cons_read_data_d [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0]   req;
  logic                       pick_found;
  logic [ID_BITS-1:0]         pick_winner;

  // Read-only instances never see write requests, so no write grant can occur.
  assign req = consumer_read_valid |
               ((WRITE_ENABLE != 0) ? consumer_write_valid : '0);

  rr_picker #(
    .N   (NUM_CONSUMERS),
    .IDB (ID_BITS)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_id_d         = grant_id_q;
    grant_count_d      = grant_count_q;
    mem_read_valid_d   = mem_read_valid_q;
    mem_read_addr_d    = mem_read_addr_q;
    mem_write_valid_d  = mem_write_valid_q;
    mem_write_addr_d   = mem_write_addr_q;
    mem_write_data_d   = mem_write_data_q;
    cons_read_ready_d  = cons_read_ready_q;
    cons_write_ready_d = cons_write_ready_q;
    cons_read_data_d   = cons_read_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_winner;
          rr_ptr_d   = (pick_winner == ID_BITS'(NUM_CONSUMERS-1)) ? '0
                                                                  : pick_winner + 1'b1;
          if (grant_count_q != '1) grant_count_d = grant_count_q + 1'b1;
          // Read wins when both are asserted; the write stays pending.
          if (consumer_read_valid[pick_winner]) begin
            mem_read_valid_d = 1'b1;
            mem_read_addr_d  = consumer_read_address[pick_winner];
            state_d          = ST_READ_WAIT;
          end else begin
            mem_write_valid_d = 1'b1;
            mem_write_addr_d  = consumer_write_address[pick_winner];
            mem_write_data_d  = consumer_write_data[pick_winner];
            state_d           = ST_WRITE_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_d             = 1'b0;
          cons_read_data_d[grant_id_q] = mem_read_data;
          cons_read_ready_d[grant_id_q] = 1'b1;
          state_d                      = ST_READ_RELAY;
        end
      end
      ST_WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_d              = 1'b0;
          cons_write_ready_d[grant_id_q] = 1'b1;
          state_d                        = ST_WRITE_RELAY;
        end
      end
      ST_READ_RELAY: begin
        if (!consumer_read_valid[grant_id_q]) begin
          cons_read_ready_d[grant_id_q] = 1'b0;
          state_d                       = ST_IDLE;
        end
      end
      ST_WRITE_RELAY: begin
        if (!consumer_write_valid[grant_id_q]) begin
          cons_write_ready_d[grant_id_q] = 1'b0;
          state_d                        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      rr_ptr_q           <= '0;
      grant_id_q         <= '0;
      grant_count_q      <= '0;
      mem_read_valid_q   <= 1'b0;
      mem_read_addr_q    <= '0;
      mem_write_valid_q  <= 1'b0;
      mem_write_addr_q   <= '0;
      mem_write_data_q   <= '0;
      cons_read_ready_q  <= '0;
      cons_write_ready_q <= '0;
      cons_read_data_q   <= '{default: '0};
    end else begin
      state_q            <= state_d;
      rr_ptr_q           <= rr_ptr_d;
      grant_id_q         <= grant_id_d;
      grant_count_q      <= grant_count_d;
      mem_read_valid_q   <= mem_read_valid_d;
      mem_read_addr_q    <= mem_read_addr_d;
      mem_write_valid_q  <= mem_write_valid_d;
      mem_write_addr_q   <= mem_write_addr_d;
      mem_write_data_q   <= mem_write_data_d;
      cons_read_ready_q  <= cons_read_ready_d;
      cons_write_ready_q <= cons_write_ready_d;
      cons_read_data_q   <= cons_read_data_d;
    end
  end

  assign consumer_read_ready = cons_read_ready_q;
  assign consumer_read_data  = cons_read_data_q;
  assign mem_read_valid      = mem_read_valid_q;
  assign mem_read_address    = mem_read_addr_q;
  assign arb_busy            = (state_q != ST_IDLE);
  assign arb_grant_id        = grant_id_q;
  assign arb_grant_count     = grant_count_q;
  assign arb_state           = state_q;

  generate
    if (WRITE_ENABLE != 0) begin : g_write
      assign mem_write_valid      = mem_write_valid_q;
      assign mem_write_address    = mem_write_addr_q;
      assign mem_write_data       = mem_write_data_q;
      assign consumer_write_ready = cons_write_ready_q;
    end else begin : g_no_write
      assign mem_write_valid      = 1'b0;
      assign mem_write_address    = '0;
      assign mem_write_data       = '0;
      assign consumer_write_ready = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a read/write instance with a vector table
// plus hand sequences, and a read-only 4-bit-counter instance.
module tb_mem_rr_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [3:0]  crv, cwv, crr, cwr;
  logic [7:0]  cra [4];
  logic [7:0]  cwa [4];
  logic [15:0] cwd [4];
  logic [15:0] crd [4];
  logic        mrv, mrr, mwv, mwr, busy;
  logic [7:0]  mra, mwa;
  logic [15:0] mrd, mwd;
  logic [1:0]  gid;
  logic [15:0] gcnt;
  logic [2:0]  st;

  // Instance B: read-only, 4-bit counter
  logic [3:0]  crv_b, cwv_b, crr_b, cwr_b;
  logic [7:0]  cra_b [4];
  logic [7:0]  cwa_b [4];
  logic [15:0] cwd_b [4];
  logic [15:0] crd_b [4];
  logic        mrv_b, mrr_b, mwv_b, mwr_b, busy_b;
  logic [7:0]  mra_b, mwa_b;
  logic [15:0] mrd_b, mwd_b;
  logic [1:0]  gid_b;
  logic [3:0]  gcnt_b;
  logic [2:0]  st_b;

  mem_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr),
    .arb_busy(busy), .arb_grant_id(gid), .arb_grant_count(gcnt),
    .arb_state(st)
  );

  mem_rr_arbiter #(.WRITE_ENABLE(0), .CNT_BITS(4)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv_b), .consumer_read_address(cra_b),
    .consumer_read_ready(crr_b), .consumer_read_data(crd_b),
    .consumer_write_valid(cwv_b), .consumer_write_address(cwa_b),
    .consumer_write_data(cwd_b), .consumer_write_ready(cwr_b),
    .mem_read_valid(mrv_b), .mem_read_address(mra_b),
    .mem_read_ready(mrr_b), .mem_read_data(mrd_b),
    .mem_write_valid(mwv_b), .mem_write_address(mwa_b),
    .mem_write_data(mwd_b), .mem_write_ready(mwr_b),
    .arb_busy(busy_b), .arb_grant_id(gid_b), .arb_grant_count(gcnt_b),
    .arb_state(st_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    crv = '0; cwv = '0; mrr = 1'b0; mwr = 1'b0; mrd = '0;
    crv_b = '0; cwv_b = '0; mrr_b = 1'b0; mwr_b = 1'b0; mrd_b = '0;
    for (int k = 0; k < 4; k++) begin
      cra[k] = 8'h40 + 8'(k); cwa[k] = 8'h80 + 8'(k); cwd[k] = 16'h5000 + 16'(k);
      cra_b[k] = 8'h60 + 8'(k); cwa_b[k] = 8'h90 + 8'(k); cwd_b[k] = 16'h7000 + 16'(k);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_read_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mrv) ok = 1'b1;
    end
    check("read_grant_seen", 32'(ok), 32'd1);
  endtask

  task automatic serve_read(input logic [15:0] data, output logic [7:0] addr,
                            output logic [1:0] id);
    bit ok;
    wait_read_grant(ok);
    addr = mra;
    id   = gid;
    mrr  = 1'b1;
    mrd  = data;
    @(negedge clk);
    mrr  = 1'b0;
  endtask

  task automatic serve_write(output logic [7:0] addr, output logic [15:0] data,
                             output logic [1:0] id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mwv) ok = 1'b1;
    end
    check("write_grant_seen", 32'(ok), 32'd1);
    addr = mwa;
    data = mwd;
    id   = gid;
    mwr  = 1'b1;
    @(negedge clk);
    mwr  = 1'b0;
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  id;
    int          exp_cnt;
    int          bad_mwv, bad_cwr, bad_busy;
    bit          ok;

    // Grant sequence from reset, pointer carried across records.
    vecs[0] = '{4'b0100, 2'd2};
    vecs[1] = '{4'b1111, 2'd3};
    vecs[2] = '{4'b1111, 2'd0};
    vecs[3] = '{4'b0001, 2'd0};
    vecs[4] = '{4'b1010, 2'd1};
    vecs[5] = '{4'b1010, 2'd3};
    vecs[6] = '{4'b0110, 2'd1};
    vecs[7] = '{4'b1001, 2'd3};
    vecs[8] = '{4'b1000, 2'd3};
    vecs[9] = '{4'b0011, 2'd0};

    do_reset();
    check("rst_mem_read_valid", 32'(mrv), 0);
    check("rst_mem_write_valid", 32'(mwv), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(st), 0);
    check("rst_grant_id", 32'(gid), 0);
    check("rst_grant_count", 32'(gcnt), 0);
    check("rst_cons_read_ready", 32'(crr), 0);
    check("rst_cons_read_data0", 32'(crd[0]), 0);

    // Read-only instance: a held write request must never be granted.
    bad_mwv = 0; bad_cwr = 0; bad_busy = 0;
    cwv_b[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mwv_b !== 1'b0) bad_mwv++;
      if (cwr_b !== 4'b0) bad_cwr++;
      if (busy_b !== 1'b0) bad_busy++;
    end
    cwv_b[0] = 1'b0;
    check("ro_mem_write_valid_cycles", 32'(bad_mwv), 0);
    check("ro_cons_write_ready_cycles", 32'(bad_cwr), 0);
    check("ro_busy_cycles", 32'(bad_busy), 0);

    // Counter saturation on the 4-bit instance.
    for (int g = 1; g <= 20; g++) begin
      crv_b[0] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (mrv_b) ok = 1'b1;
      end
      check("sat_grant_seen", 32'(ok), 1);
      mrr_b = 1'b1; mrd_b = 16'(g);
      @(negedge clk);
      mrr_b = 1'b0;
      crv_b[0] = 1'b0;
      @(negedge clk);
      check($sformatf("sat_count_g%0d", g), 32'(gcnt_b), (g > 15) ? 15 : g);
    end

    // Single read with exact latencies.
    do_reset();
    cra[2] = 8'h3C;
    crv[2] = 1'b1;
    @(negedge clk);
    check("single_mem_read_valid", 32'(mrv), 1);
    check("single_mem_addr", 32'(mra), 32'h3C);
    check("single_grant_id", 32'(gid), 2);
    check("single_busy", 32'(busy), 1);
    check("single_count", 32'(gcnt), 1);
    repeat (3) @(negedge clk);
    check("single_wait_valid_held", 32'(mrv), 1);
    check("single_wait_no_ready", 32'(crr), 0);
    mrr = 1'b1; mrd = 16'h1234;
    @(negedge clk);
    mrr = 1'b0;
    check("single_cons_ready", 32'(crr), 32'b0100);
    check("single_cons_data", 32'(crd[2]), 32'h1234);
    check("single_mem_valid_dropped", 32'(mrv), 0);
    @(negedge clk);
    check("single_relay_hold", 32'(crr), 32'b0100);
    crv[2] = 1'b0;
    @(negedge clk);
    check("single_release_ready", 32'(crr), 0);
    check("single_release_busy", 32'(busy), 0);
    check("single_data_retained", 32'(crd[2]), 32'h1234);

    // Table-driven grant order.
    do_reset();
    exp_cnt = 0;
    for (int v = 0; v < 10; v++) begin
      crv = vecs[v].mask;
      serve_read(16'hA000 + 16'(v), a, id);
      exp_cnt++;
      check($sformatf("vec%0d_grant_id", v), 32'(id), 32'(vecs[v].exp_id));
      check($sformatf("vec%0d_mem_addr", v), 32'(a), 32'(8'h40 + 8'(vecs[v].exp_id)));
      check($sformatf("vec%0d_cons_ready", v), 32'(crr), 32'(4'b0001 << vecs[v].exp_id));
      check($sformatf("vec%0d_cons_data", v), 32'(crd[vecs[v].exp_id]), 32'(16'hA000 + 16'(v)));
      check($sformatf("vec%0d_count", v), 32'(gcnt), 32'(exp_cnt));
      crv = '0;
      @(negedge clk);
      check($sformatf("vec%0d_idle", v), 32'(busy), 0);
    end

    // Continuous requests from all four: strict rotation.
    do_reset();
    crv = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      serve_read(16'h0B00 + 16'(g), a, id);
      check($sformatf("rr_order_%0d", g), 32'(id), 32'(g % 4));
      crv[id] = 1'b0;
      @(negedge clk);
      crv[id] = 1'b1;
    end
    crv = '0;

    // Read beats write for the same consumer; write follows on next grant.
    do_reset();
    cra[1] = 8'h10; cwa[1] = 8'h20; cwd[1] = 16'hBEEF;
    crv[1] = 1'b1; cwv[1] = 1'b1;
    serve_read(16'h0001, a, id);
    check("prio_read_addr", 32'(a), 32'h10);
    check("prio_read_id", 32'(id), 1);
    check("prio_read_ready", 32'(crr), 32'b0010);
    check("prio_no_write_ready", 32'(cwr), 0);
    crv[1] = 1'b0;
    serve_write(a, d, id);
    check("prio_write_addr", 32'(a), 32'h20);
    check("prio_write_data", 32'(d), 32'hBEEF);
    check("prio_write_id", 32'(id), 1);
    check("prio_write_ready", 32'(cwr), 32'b0010);
    check("prio_count", 32'(gcnt), 2);
    cwv[1] = 1'b0;
    @(negedge clk);
    check("prio_write_release", 32'(cwr), 0);

    // Reset in READ_WAIT aborts and restarts the pointer.
    do_reset();
    crv[2] = 1'b1;
    wait_read_grant(ok);
    reset = 1'b1;
    crv = '0;
    @(negedge clk);
    check("midrst_mem_read_valid", 32'(mrv), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_count", 32'(gcnt), 0);
    check("midrst_grant_id", 32'(gid), 0);
    check("midrst_cons_ready", 32'(crr), 0);
    reset = 1'b0;
    crv[1] = 1'b1; crv[3] = 1'b1;
    wait_read_grant(ok);
    check("midrst_ptr_restart_id", 32'(gid), 1);
    check("midrst_new_count", 32'(gcnt), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
